// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: decode operands, redirect,
// memory freeze in; stall, flush, halt and debug counters out.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             idValid;
   logic [2:0]       idRs;
   logic             idRsVld;
   logic [2:0]       idRt;
   logic             idRtVld;
   logic             idRegWrt;
   logic [2:0]       idWriteReg;
   logic             idHalt;
   logic             exRedirect;
   logic             memStall;
   logic             stall;
   logic             flushPipe;
   logic             halted;
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   modport master (
      output idValid, idRs, idRsVld, idRt, idRtVld,
      output idRegWrt, idWriteReg, idHalt,
      output exRedirect, memStall,
      input  stall, flushPipe, halted, stallCnt, flushCnt
   );

   modport slave (
      input  idValid, idRs, idRsVld, idRt, idRtVld,
      input  idRegWrt, idWriteReg, idHalt,
      input  exRedirect, memStall,
      output stall, flushPipe, halted, stallCnt, flushCnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Interlock/flush controller: shift-register scoreboard of in-flight
// destinations, RAW stall, redirect flush, halt latch, debug counters.
module hazard_ctrl #(
   parameter int DEPTH  = 3,
   parameter int SQUASH = 1,
   parameter int CNT_W  = 16
) (
   input logic         clk,
   input logic         rst,
   hazard_ctrl_if.slave hz
);

   logic [DEPTH-1:0] vld_q, vld_d;
   logic [2:0]       rd_q [DEPTH];
   logic [2:0]       rd_d [DEPTH];
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic rs_hit, rt_hit;
   logic hazard, flush, stall, issue;

   // Compare decode sources against every live slot (r0 included).
   always_comb begin
      rs_hit = 1'b0;
      rt_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && rd_q[i] == hz.idRs) rs_hit = 1'b1;
         if (vld_q[i] && rd_q[i] == hz.idRt) rt_hit = 1'b1;
      end
   end

   assign hazard = hz.idValid & ~halted_q &
                   ((hz.idRsVld & rs_hit) | (hz.idRtVld & rt_hit));
   assign flush  = hz.exRedirect & ~hz.memStall;
   assign stall  = hz.memStall | halted_q | (hazard & ~flush);
   assign issue  = hz.idValid & ~stall & ~flush;

   // Advance scoreboard, halt and counters; a memory freeze holds all.
   always_comb begin
      vld_d       = vld_q;
      rd_d        = rd_q;
      halted_d    = halted_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!hz.memStall) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            vld_d[i] = vld_q[i-1];
            rd_d[i]  = rd_q[i-1];
         end
         vld_d[0] = issue & hz.idRegWrt;
         rd_d[0]  = hz.idWriteReg;
         if (flush) begin
            for (int i = 1; i <= SQUASH; i++) begin
               if (i < DEPTH) vld_d[i] = 1'b0;
            end
            vld_d[0] = 1'b0;
         end
         if (issue & hz.idHalt) halted_d = 1'b1;
         if (hazard && !flush && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (flush && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // State registers, cleared by the synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q       <= '0;
         for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
         halted_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         vld_q       <= vld_d;
         rd_q        <= rd_d;
         halted_q    <= halted_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.stall     = stall;
   assign hz.flushPipe = flush;
   assign hz.halted    = halted_q;
   assign hz.stallCnt  = stall_cnt_q;
   assign hz.flushCnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against
// an age-list reference model; a 4-bit counter copy checks saturation.
module tb_hazard_ctrl;

   localparam int DEPTH  = 3;
   localparam int SQUASH = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       idValid, idRsVld, idRtVld, idRegWrt, idHalt;
   logic       exRedirect, memStall;
   logic [2:0] idRs, idRt, idWriteReg;

   hazard_ctrl_if #(.CNT_W(16)) bus16 ();
   hazard_ctrl_if #(.CNT_W(4))  bus4 ();

   assign bus16.idValid    = idValid;
   assign bus16.idRs       = idRs;
   assign bus16.idRsVld    = idRsVld;
   assign bus16.idRt       = idRt;
   assign bus16.idRtVld    = idRtVld;
   assign bus16.idRegWrt   = idRegWrt;
   assign bus16.idWriteReg = idWriteReg;
   assign bus16.idHalt     = idHalt;
   assign bus16.exRedirect = exRedirect;
   assign bus16.memStall   = memStall;
   assign bus4.idValid     = idValid;
   assign bus4.idRs        = idRs;
   assign bus4.idRsVld     = idRsVld;
   assign bus4.idRt        = idRt;
   assign bus4.idRtVld     = idRtVld;
   assign bus4.idRegWrt    = idRegWrt;
   assign bus4.idWriteReg  = idWriteReg;
   assign bus4.idHalt      = idHalt;
   assign bus4.exRedirect  = exRedirect;
   assign bus4.memStall    = memStall;

   hazard_ctrl #(.DEPTH(DEPTH), .SQUASH(SQUASH), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (bus16.slave)
   );

   hazard_ctrl #(.DEPTH(DEPTH), .SQUASH(SQUASH), .CNT_W(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .hz  (bus4.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: list of in-flight writers with their age in cycles.
   typedef struct {
      int rd;
      int age;
   } ent_t;

   ent_t sb[$];
   bit   m_halted;
   int   m_scnt, m_fcnt;

   function automatic bit m_hazard();
      bit hit = 0;
      if (!idValid || m_halted) return 0;
      foreach (sb[i]) begin
         if (idRsVld && sb[i].rd == int'(idRs)) hit = 1;
         if (idRtVld && sb[i].rd == int'(idRt)) hit = 1;
      end
      return hit;
   endfunction

   function automatic bit m_flush();
      return exRedirect && !memStall;
   endfunction

   function automatic bit m_stall();
      return memStall || m_halted || (m_hazard() && !m_flush());
   endfunction

   function automatic bit m_issue();
      return idValid && !m_stall() && !m_flush();
   endfunction

   function automatic int sat(int n, int w);
      int mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   task automatic step();
      bit   hz, fl, is;
      ent_t nq[$];
      hz = m_hazard();
      fl = m_flush();
      is = m_issue();
      @(posedge clk);
      if (!rst) begin
         sb.delete();
         m_halted = 0;
         m_scnt   = 0;
         m_fcnt   = 0;
      end else if (!memStall) begin
         foreach (sb[i]) begin
            if (fl && sb[i].age < SQUASH) continue;
            if (sb[i].age + 1 < DEPTH)
               nq.push_back('{sb[i].rd, sb[i].age + 1});
         end
         if (is && idRegWrt) nq.push_back('{int'(idWriteReg), 0});
         sb = nq;
         if (is && idHalt) m_halted = 1;
         if (hz && !fl) m_scnt++;
         if (fl) m_fcnt++;
      end
      #1;
   endtask

   task automatic idle_in();
      idValid    = 0;
      idRs       = 0;
      idRsVld    = 0;
      idRt       = 0;
      idRtVld    = 0;
      idRegWrt   = 0;
      idWriteReg = 0;
      idHalt     = 0;
      exRedirect = 0;
      memStall   = 0;
   endtask

   task automatic do_reset();
      idle_in();
      rst = 0;
      step();
      step();
      rst = 1;
   endtask

   task automatic drive_write(input logic [2:0] r);
      idle_in();
      idValid    = 1;
      idRegWrt   = 1;
      idWriteReg = r;
   endtask

   task automatic drive_read(input logic [2:0] r);
      idle_in();
      idValid = 1;
      idRs    = r;
      idRsVld = 1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_cmp++;
      if (bus16.stall !== 1'b0 || bus16.flushPipe !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ctl got stall=%0b flush=%0b want 0/0",
                  bus16.stall, bus16.flushPipe);
      end
      n_cmp++;
      if (bus16.halted !== 1'b0 || bus16.stallCnt !== 16'd0 ||
          bus16.flushCnt !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_state got halted=%0b sc=%0d fc=%0d want 0",
                  bus16.halted, bus16.stallCnt, bus16.flushCnt);
      end
      step();
   endtask

   task automatic test_raw();
      int n = 0;
      do_reset();
      drive_write(3'd3);
      @(negedge clk);
      step();
      idle_in();
      @(negedge clk);
      step();
      drive_read(3'd3);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_cmp++;
         if (bus16.stall !== m_stall()) begin
            n_bad++;
            $display("FAIL raw_stall cyc%0d got %0b want %0b",
                     k, bus16.stall, m_stall());
         end
         if (!bus16.stall) break;
         n++;
         step();
      end
      n_cmp++;
      if (n != 2) begin
         n_bad++;
         $display("FAIL raw_stall_len got %0d want 2", n);
      end
      n_cmp++;
      if (bus16.stallCnt !== 16'd2) begin
         n_bad++;
         $display("FAIL raw_stallcnt got %0d want 2", bus16.stallCnt);
      end
      step();
      drive_write(3'd3);
      @(negedge clk);
      step();
      idle_in();
      @(negedge clk);
      step();
      drive_read(3'd4);
      @(negedge clk);
      n_cmp++;
      if (bus16.stall !== 1'b0) begin
         n_bad++;
         $display("FAIL raw_nodep got %0b want 0", bus16.stall);
      end
      step();
   endtask

   task automatic test_flush();
      do_reset();
      drive_write(3'd5);
      @(negedge clk);
      step();
      idle_in();
      exRedirect = 1;
      @(negedge clk);
      n_cmp++;
      if (bus16.flushPipe !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_pulse got %0b want 1", bus16.flushPipe);
      end
      step();
      drive_read(3'd5);
      @(negedge clk);
      n_cmp++;
      if (bus16.flushPipe !== 1'b0 || bus16.stall !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_after got flush=%0b stall=%0b want 0/0",
                  bus16.flushPipe, bus16.stall);
      end
      n_cmp++;
      if (bus16.flushCnt !== 16'd1) begin
         n_bad++;
         $display("FAIL flush_cnt got %0d want 1", bus16.flushCnt);
      end
      step();
   endtask

   task automatic test_hazard_flush();
      do_reset();
      drive_write(3'd1);
      @(negedge clk);
      step();
      drive_read(3'd1);
      idHalt     = 1;
      exRedirect = 1;
      @(negedge clk);
      n_cmp++;
      if (bus16.stall !== 1'b0 || bus16.flushPipe !== 1'b1) begin
         n_bad++;
         $display("FAIL hzflush got stall=%0b flush=%0b want 0/1",
                  bus16.stall, bus16.flushPipe);
      end
      step();
      idle_in();
      @(negedge clk);
      n_cmp++;
      if (bus16.halted !== 1'b0 || bus16.stallCnt !== 16'd0) begin
         n_bad++;
         $display("FAIL hzflush_state got halted=%0b sc=%0d want 0/0",
                  bus16.halted, bus16.stallCnt);
      end
      step();
   endtask

   task automatic test_memstall();
      int n = 0;
      do_reset();
      drive_write(3'd2);
      @(negedge clk);
      step();
      idle_in();
      @(negedge clk);
      step();
      drive_read(3'd2);
      memStall = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++;
         if (bus16.stall !== 1'b1 || bus16.stallCnt !== 16'd0) begin
            n_bad++;
            $display("FAIL mem_freeze cyc%0d got stall=%0b sc=%0d want 1/0",
                     k, bus16.stall, bus16.stallCnt);
         end
         step();
      end
      memStall = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (!bus16.stall) break;
         n++;
         step();
      end
      n_cmp++;
      if (n != 2 || bus16.stallCnt !== 16'd2) begin
         n_bad++;
         $display("FAIL mem_release got n=%0d sc=%0d want 2/2",
                  n, bus16.stallCnt);
      end
      step();
   endtask

   task automatic test_halt();
      do_reset();
      idle_in();
      idValid = 1;
      idHalt  = 1;
      @(negedge clk);
      step();
      idle_in();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if (bus16.halted !== 1'b1 || bus16.stall !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_hold cyc%0d got h=%0b s=%0b want 1/1",
                     k, bus16.halted, bus16.stall);
         end
         step();
      end
      do_reset();
      @(negedge clk);
      n_cmp++;
      if (bus16.halted !== 1'b0 || bus16.stall !== 1'b0) begin
         n_bad++;
         $display("FAIL halt_reset got h=%0b s=%0b want 0/0",
                  bus16.halted, bus16.stall);
      end
      step();
   endtask

   task automatic test_saturate();
      do_reset();
      idle_in();
      idValid    = 1;
      idRs       = 3'd6;
      idRsVld    = 1;
      idRegWrt   = 1;
      idWriteReg = 3'd6;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         step();
      end
      idle_in();
      @(negedge clk);
      n_cmp++;
      if (m_scnt < 20 || bus4.stallCnt !== 4'd15) begin
         n_bad++;
         $display("FAIL sat_cnt4 got %0d want 15 (model %0d)",
                  bus4.stallCnt, m_scnt);
      end
      n_cmp++;
      if (int'(bus16.stallCnt) != m_scnt) begin
         n_bad++;
         $display("FAIL sat_cnt16 got %0d want %0d",
                  bus16.stallCnt, m_scnt);
      end
      step();
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         idValid    = ($urandom_range(0, 3) != 0);
         idRs       = 3'($urandom_range(0, 3));
         idRsVld    = $urandom_range(0, 1) != 0;
         idRt       = 3'($urandom_range(0, 3));
         idRtVld    = $urandom_range(0, 1) != 0;
         idRegWrt   = $urandom_range(0, 2) != 0;
         idWriteReg = 3'($urandom_range(0, 3));
         idHalt     = ($urandom_range(0, 299) == 0);
         exRedirect = ($urandom_range(0, 5) == 0);
         memStall   = ($urandom_range(0, 4) == 0);
         @(negedge clk);
         n_cmp++;
         if (bus16.stall !== m_stall() || bus16.flushPipe !== m_flush()) begin
            n_bad++;
            $display("FAIL rnd_ctl cyc%0d got s=%0b f=%0b want s=%0b f=%0b",
                     k, bus16.stall, bus16.flushPipe, m_stall(), m_flush());
         end
         n_cmp++;
         if (bus16.halted !== m_halted) begin
            n_bad++;
            $display("FAIL rnd_halt cyc%0d got %0b want %0b",
                     k, bus16.halted, m_halted);
         end
         n_cmp++;
         if (int'(bus16.stallCnt) != m_scnt ||
             int'(bus16.flushCnt) != m_fcnt) begin
            n_bad++;
            $display("FAIL rnd_cnt16 cyc%0d got %0d/%0d want %0d/%0d",
                     k, bus16.stallCnt, bus16.flushCnt, m_scnt, m_fcnt);
         end
         n_cmp++;
         if (int'(bus4.stallCnt) != sat(m_scnt, 4) ||
             int'(bus4.flushCnt) != sat(m_fcnt, 4)) begin
            n_bad++;
            $display("FAIL rnd_cnt4 cyc%0d got %0d/%0d want %0d/%0d",
                     k, bus4.stallCnt, bus4.flushCnt,
                     sat(m_scnt, 4), sat(m_fcnt, 4));
         end
         if (k == 250) rst = 0;
         step();
         rst = 1;
      end
   endtask

   initial begin
      rst = 0;
      idle_in();
      #1;
      test_reset();
      test_raw();
      test_flush();
      test_hazard_flush();
      test_memstall();
      test_halt();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
